// File: rtl/instruction_memory_loadable.sv
// Runtime-loadable instruction memory: byte-stream loader with zero padding of the
// final word, and a registered, stallable fetch port that flags bad fetches.
module instruction_memory_loadable #(
    parameter int          DEPTH_WORDS = 64,
    parameter int          PC_WIDTH    = 32,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0000,
    localparam int         LW_W        = $clog2(DEPTH_WORDS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_start,
    input  logic                load_valid,
    input  logic [7:0]          load_data,
    input  logic                load_last,
    output logic                load_ready,
    output logic                load_err,
    output logic [LW_W-1:0]     loaded_words,
    output logic                busy,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                fetch_en,
    output logic [31:0]         instruction,
    output logic                instr_valid,
    output logic                fetch_fault
);

    localparam int               IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int               PTR_W   = IDX_W + 2;
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(4 * DEPTH_WORDS - 1);
    localparam int               CMP_W   = (PC_WIDTH > LW_W) ? PC_WIDTH : LW_W;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_PAD, ST_RUN} state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [LW_W-1:0]   loaded_q, loaded_d;
    logic              err_q, err_d;
    logic [31:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              fault_q, fault_d;

    logic              wr_en;
    logic [7:0]        wr_byte;
    logic [LW_W-1:0]   words_at_ptr;
    logic              in_range;
    logic [31:0]       mem_q [DEPTH_WORDS];

    // Word count once ptr sits on the last byte of a word.
    assign words_at_ptr = LW_W'(ptr_q[PTR_W-1:2]) + LW_W'(1);
    assign in_range     = CMP_W'(pc >> 2) < CMP_W'(loaded_q);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        loaded_d = loaded_q;
        err_d    = err_q;
        wr_en    = 1'b0;
        wr_byte  = load_data;

        if (load_start) begin
            state_d  = ST_LOAD;
            ptr_d    = '0;
            loaded_d = '0;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (load_valid && load_ready) begin
                        wr_en = 1'b1;
                        ptr_d = ptr_q + PTR_W'(1);
                        if (load_last) begin
                            if (ptr_q[1:0] == 2'b11) begin
                                state_d  = ST_RUN;
                                loaded_d = words_at_ptr;
                            end else begin
                                state_d = ST_PAD;
                            end
                        end else if (ptr_q == PTR_MAX) begin
                            state_d  = ST_RUN;
                            loaded_d = LW_W'(DEPTH_WORDS);
                            err_d    = 1'b1;
                        end
                    end
                end
                ST_PAD: begin
                    wr_en   = 1'b1;
                    wr_byte = 8'h00;
                    ptr_d   = ptr_q + PTR_W'(1);
                    if (ptr_q[1:0] == 2'b11) begin
                        state_d  = ST_RUN;
                        loaded_d = words_at_ptr;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        instr_d = instr_q;
        valid_d = valid_q;
        fault_d = fault_q;

        if (load_start || state_q == ST_LOAD || state_q == ST_PAD) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
            fault_d = 1'b0;
        end else if (fetch_en) begin
            if (pc[1:0] != 2'b00 || !in_range) begin
                instr_d = NOP_WORD;
                valid_d = 1'b0;
                fault_d = 1'b1;
            end else begin
                instr_d = mem_q[pc[IDX_W+1:2]];
                valid_d = 1'b1;
                fault_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            loaded_q <= '0;
            err_q    <= 1'b0;
            instr_q  <= NOP_WORD;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            loaded_q <= loaded_d;
            err_q    <= err_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            fault_q  <= fault_d;
        end
    end

    // NOTE: storage has no reset; loaded_words=0 already makes stale contents unreachable.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[ptr_q[PTR_W-1:2]][{~ptr_q[1:0], 3'b000} +: 8] <= wr_byte;
        end
    end

    assign load_ready   = (state_q == ST_LOAD);
    assign busy         = (state_q == ST_LOAD) || (state_q == ST_PAD);
    assign load_err     = err_q;
    assign loaded_words = loaded_q;
    assign instruction  = instr_q;
    assign instr_valid  = valid_q;
    assign fetch_fault  = fault_q;

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Directed bench for instruction_memory_loadable built with DEPTH_WORDS=2 so the
// overflow path is reachable alongside the normal load, pad and fetch cases.
module tb_instruction_memory_loadable;

    localparam int          DEPTH = 2;
    localparam int          LW_W  = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            rst;
    logic            load_start, load_valid, load_last;
    logic [7:0]      load_data;
    logic            load_ready, load_err, busy;
    logic [LW_W-1:0] loaded_words;
    logic [31:0]     pc;
    logic            fetch_en;
    logic [31:0]     instruction;
    logic            instr_valid, fetch_fault;

    int total = 0;
    int bad   = 0;

    instruction_memory_loadable #(
        .DEPTH_WORDS(DEPTH),
        .PC_WIDTH   (32),
        .NOP_WORD   (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .load_err    (load_err),
        .loaded_words(loaded_words),
        .busy        (busy),
        .pc          (pc),
        .fetch_en    (fetch_en),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        int n = 0;
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        while (!load_ready && n < 20) begin
            step();
            n++;
        end
        if (!load_ready) check("ready_timeout", {31'b0, load_ready}, 32'd1);
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr);
        fetch_en = 1'b1;
        pc       = addr;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] img1 [8];
        logic [7:0] img2 [8];
        int         acc, n;
        logic       rdy;
        img1 = '{8'h8C, 8'h10, 8'h00, 8'h00, 8'h8C, 8'h11, 8'h00, 8'h04};
        img2 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};

        rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        load_data = 8'h00; pc = 32'h0; fetch_en = 1'b0;
        step(); step();
        rst = 1'b0;

        check("rst_ready", {31'b0, load_ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_err", {31'b0, load_err}, 32'd0);
        check("rst_words", 32'(loaded_words), 32'd0);
        check("rst_instr", instruction, NOP);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_fault", {31'b0, fetch_fault}, 32'd0);

        fetch(32'h0);
        check("empty_instr", instruction, NOP);
        check("empty_valid", {31'b0, instr_valid}, 32'd0);
        check("empty_fault", {31'b0, fetch_fault}, 32'd1);

        // Exact 8-byte image.
        start_load();
        check("l1_busy", {31'b0, busy}, 32'd1);
        check("l1_ready", {31'b0, load_ready}, 32'd1);
        check("l1_fault_in_load", {31'b0, fetch_fault}, 32'd0);
        for (int i = 0; i < 8; i++) send(img1[i], i == 7);
        check("l1_words", 32'(loaded_words), 32'd2);
        check("l1_err", {31'b0, load_err}, 32'd0);
        check("l1_busy_done", {31'b0, busy}, 32'd0);
        check("l1_edge_valid", {31'b0, instr_valid}, 32'd0);
        fetch(32'h0);
        check("l1_pc0", instruction, 32'h8C10_0000);
        check("l1_pc0_valid", {31'b0, instr_valid}, 32'd1);
        fetch(32'h4);
        check("l1_pc4", instruction, 32'h8C11_0004);
        fetch(32'h8);
        check("l1_pc8_fault", {31'b0, fetch_fault}, 32'd1);
        check("l1_pc8_valid", {31'b0, instr_valid}, 32'd0);
        check("l1_pc8_instr", instruction, NOP);

        // 6-byte image padded to two words.
        fetch_en = 1'b1; pc = 32'h0;
        start_load();
        send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0);
        send(8'hDD, 1'b0); send(8'h11, 1'b0); send(8'h22, 1'b1);
        check("pad_busy1", {31'b0, busy}, 32'd1);
        check("pad_ready", {31'b0, load_ready}, 32'd0);
        step();
        check("pad_busy2", {31'b0, busy}, 32'd1);
        step();
        check("pad_busy_done", {31'b0, busy}, 32'd0);
        check("pad_words", 32'(loaded_words), 32'd2);
        check("pad_edge_valid", {31'b0, instr_valid}, 32'd0);
        fetch(32'h4);
        check("pad_pc4", instruction, 32'h1122_0000);
        fetch(32'h0);
        check("pad_pc0", instruction, 32'hAABB_CCDD);
        fetch(32'h4000_0000);
        check("pad_far_fault", {31'b0, fetch_fault}, 32'd1);
        fetch(32'h6);
        check("pad_misalign", {31'b0, fetch_fault}, 32'd1);

        // Overflow: 9 bytes into 8 bytes of storage, no last.
        fetch_en = 1'b0;
        start_load();
        for (int i = 0; i < 8; i++) send(img2[i], 1'b0);
        check("ovf_ready", {31'b0, load_ready}, 32'd0);
        check("ovf_err", {31'b0, load_err}, 32'd1);
        check("ovf_words", 32'(loaded_words), 32'd2);
        load_valid = 1'b1; load_data = 8'h55;
        step(); step();
        load_valid = 1'b0;
        check("ovf_err_hold", {31'b0, load_err}, 32'd1);
        check("ovf_busy", {31'b0, busy}, 32'd0);
        fetch(32'h0);
        check("ovf_pc0", instruction, 32'h1011_1213);
        fetch(32'h4);
        check("ovf_pc4", instruction, 32'h1415_1617);

        // Randomly gapped stream, aborted by load_start racing a byte.
        fetch_en = 1'b0;
        start_load();
        check("rl_err_clear", {31'b0, load_err}, 32'd0);
        acc = 0; n = 0;
        while (acc < 3 && n < 50) begin
            load_valid = 1'($urandom_range(0, 1));
            load_data  = 8'hE0 + 8'(acc);
            rdy        = load_ready;
            step();
            if (load_valid && rdy) acc++;
            n++;
        end
        check("rl_rand_accept", 32'(acc), 32'd3);
        load_start = 1'b1; load_valid = 1'b1; load_data = 8'hFF;
        step();
        load_start = 1'b0; load_valid = 1'b0;
        check("rl_restart_words", 32'(loaded_words), 32'd0);
        check("rl_restart_busy", {31'b0, busy}, 32'd1);
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b1);
        check("rl_words", 32'(loaded_words), 32'd1);
        fetch(32'h0);
        check("rl_pc0", instruction, 32'h0102_0304);
        fetch_en = 1'b0; pc = 32'h4;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_instr", instruction, 32'h0102_0304);
            check("stall_valid", {31'b0, instr_valid}, 32'd1);
        end
        fetch(32'h2);
        check("rl_pc2_fault", {31'b0, fetch_fault}, 32'd1);

        // Reset in the middle of padding.
        fetch_en = 1'b1; pc = 32'h0;
        start_load();
        send(8'h9A, 1'b0); send(8'h9B, 1'b1);
        check("rp_in_pad", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rp_busy", {31'b0, busy}, 32'd0);
        check("rp_ready", {31'b0, load_ready}, 32'd0);
        check("rp_words", 32'(loaded_words), 32'd0);
        check("rp_instr", instruction, NOP);
        check("rp_valid", {31'b0, instr_valid}, 32'd0);
        check("rp_fault", {31'b0, fetch_fault}, 32'd0);
        fetch(32'h0);
        check("rp_fetch_fault", {31'b0, fetch_fault}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
